bit_serial_alu: RTL and testbench
=================================

# bit_serial_alu

Parametrised bit-serial ALU: accepts two WIDTH-bit operands and a 2-bit opcode, then computes AND/OR/ADD/SUB one bit per clock, LSB first, through a single 1-bit cell with a registered carry. Generalises the team's parallel 8-bit ALU to arbitrary width, adds a start/busy/done handshake, and adds status flags. It is the execution unit of the bit-serial CPU datapath.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  opcode: 0 AND, 1 OR, 2 ADD, 3 SUB (a − b).
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- busy  output  1  high while state ≠ IDLE.
- done  output  1  one-cycle pulse; result and flags are valid.
- result  output  WIDTH  registered result; held until the next done.
- flag_z  output  1  result == 0.
- flag_c  output  1  carry out (ADD), no-borrow (SUB), 0 for logic ops.
- flag_v  output  1  signed overflow (ADD/SUB), 0 for logic ops.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1: latch a, b, op into shift registers; load carry = (op==SUB); load bit counter = 0; go to RUN. start=0: stay in IDLE.
- RUN, each cycle:
  - Cell computes bit = f(a[0], b'[0], carry), where b' = ~b for SUB.
  - Shift bit into the internal result MSB. Shift a and b right. Update carry. Increment counter.
  - After the cycle with counter == WIDTH−1: copy the internal result to `result`, compute flags, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Arithmetic:
  - SUB = a + ~b + 1, modulo 2^WIDTH.
  - flag_c = final carry.
  - flag_v = carry into MSB XOR carry out of MSB. Track the carry into the MSB in the last RUN cycle.
- The a/b/op inputs are ignored outside an accepted start. Changes during RUN have no effect.
- start while busy (RUN or DONE) is ignored, not queued.
- Outputs never show partial results. `result` and the flags change only on entry to DONE.

## Timing
- Reset values: busy=0, done=0, result=0, flag_z=0, flag_c=0, flag_v=0; state IDLE.
- Start accepted at edge E0. Bits 0..WIDTH−1 are processed at edges E1..E_WIDTH. done is high in the cycle after E_WIDTH (latency WIDTH+1 edges). busy falls at E_(WIDTH+1).
- Minimum start-to-start spacing: WIDTH+2 cycles. A start held high is re-accepted in the first IDLE cycle.
- rst has priority over everything:
  - rst mid-RUN or in DONE returns to IDLE, clears all outputs, and emits no done.
  - start in the same cycle as rst is ignored.
- The counter is ⌈log2(WIDTH)⌉+1 bits wide; it does not wrap within an operation.

## Configuration
- BIT_SERIAL_ALU_FLAGS_EN defined: flag_z/flag_c/flag_v are computed and registered as above.
- Not defined:
  - Flag ports remain in the interface, tied to constant 0, and no flag registers are built.
  - The carry register still exists because ADD/SUB need it.
  - result, done and busy behaviour is identical.

## Structure
- Package bit_serial_alu_pkg:
  - Opcode constants OP_AND=2'd0, OP_OR=2'd1, OP_ADD=2'd2, OP_SUB=2'd3.
  - FSM state typedef (IDLE, RUN, DONE).
- Sub-module alu_bit_cell, purely combinational:
  - Inputs: a_bit, b_bit, cin, op.
  - Outputs: r, cout.
  - Performs the b inversion for SUB internally.
- Top level holds the FSM, counter, shift registers, carry, output registers and flag logic.

## Test plan
- WIDTH=8, ADD a=8'h3C b=8'h0F → result 8'h4B, z=0 c=0 v=0. done exactly 9 edges after start accepted, one cycle wide.
- WIDTH=8, SUB a=8'h10 b=8'h10 → result 8'h00, z=1 c=1 v=0. SUB a=8'h00 b=8'h01 → 8'hFF, c=0 v=0.
- WIDTH=8, ADD 8'h7F+8'h01 → 8'h80, v=1 c=0. ADD 8'hFF+8'h01 → 8'h00, c=1 z=1 v=0.
- WIDTH=8, a=8'hF0 b=8'h3C: AND → 8'h30, OR → 8'hFC, c=0 v=0 both.
- Handshake and reset:
  - Second start pulses during RUN/DONE are ignored. a/b changed mid-RUN does not alter the result.
  - rst asserted at bit 4 → busy=0, result=0, no done pulse. Next start completes normally.
- WIDTH=16, SUB 16'h0000−16'h0001 → 16'hFFFF, c=0 v=0, done 17 edges after start. Repeat with the flags macro undefined → flags stay 0, result unchanged.

Source files
------------

// File: rtl/bit_serial_alu_pkg.sv
// Shared opcodes and FSM state type for the bit-serial ALU.
package bit_serial_alu_pkg;

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_ADD = 2'd2;
    localparam logic [1:0] OP_SUB = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/alu_bit_cell.sv
// One-bit ALU cell: AND/OR/ADD/SUB on a single bit slice with carry in/out.
module alu_bit_cell
    import bit_serial_alu_pkg::*;
(
    input  logic       a_bit,
    input  logic       b_bit,
    input  logic       cin,
    input  logic [1:0] op,
    output logic       r,
    output logic       cout
);

    logic b_eff;

    always_comb begin
        b_eff = (op == OP_SUB) ? ~b_bit : b_bit;
        r     = 1'b0;
        cout  = 1'b0;
        unique case (op)
            OP_AND: r = a_bit & b_eff;
            OP_OR:  r = a_bit | b_eff;
            default: begin
                r    = a_bit ^ b_eff ^ cin;
                cout = (a_bit & b_eff) | (a_bit & cin) | (b_eff & cin);
            end
        endcase
    end

endmodule

// File: rtl/bit_serial_alu.sv
// Bit-serial ALU top: FSM, operand shift registers, carry and output registers.
// Define BIT_SERIAL_ALU_FLAGS_EN to build the Z/C/V flag registers; otherwise flags read 0.
module bit_serial_alu
    import bit_serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             cell_r;
    logic             cell_cout;
    logic [WIDTH-1:0] acc_next;
    logic             last_bit;

    alu_bit_cell u_cell (
        .a_bit (a_q[0]),
        .b_bit (b_q[0]),
        .cin   (carry_q),
        .op    (op_q),
        .r     (cell_r),
        .cout  (cell_cout)
    );

    assign acc_next = {cell_r, acc_q[WIDTH-1:1]};
    assign last_bit = (state_q == StRun) && (cnt_q == LastBit);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    carry_d = (op == OP_SUB);
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d   = acc_next;
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                carry_d = cell_cout;
                cnt_d   = cnt_q + 1'b1;
                if (last_bit) begin
                    result_d = acc_next;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            op_q     <= OP_AND;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = (state_q == StDone);
    assign result = result_q;

`ifdef BIT_SERIAL_ALU_FLAGS_EN
    logic flag_z_q, flag_z_d;
    logic flag_c_q, flag_c_d;
    logic flag_v_q, flag_v_d;

    // carry_q in the last RUN cycle is the carry into the MSB; op_q[1] marks ADD/SUB.
    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        flag_v_d = flag_v_q;
        if (last_bit) begin
            flag_z_d = (acc_next == '0);
            flag_c_d = op_q[1] & cell_cout;
            flag_v_d = op_q[1] & (carry_q ^ cell_cout);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_v_q <= 1'b0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            flag_v_q <= flag_v_d;
        end
    end

    assign flag_z = flag_z_q;
    assign flag_c = flag_c_q;
    assign flag_v = flag_v_q;
`else
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
    assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_alu.sv
// Directed self-checking bench for bit_serial_alu at WIDTH=8 and WIDTH=16.
module tb_bit_serial_alu;

`ifdef BIT_SERIAL_ALU_FLAGS_EN
    localparam bit FlagsEn = 1'b1;
`else
    localparam bit FlagsEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic [1:0]  op8 = 2'd0;
    logic [1:0]  op16 = 2'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy8, done8, z8, c8, v8;
    logic        busy16, done16, z16, c16, v16;
    logic [7:0]  result8;
    logic [15:0] result16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serial_alu #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .start  (start8),
        .op     (op8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .result (result8),
        .flag_z (z8),
        .flag_c (c8),
        .flag_v (v8)
    );

    bit_serial_alu #(.WIDTH(16)) dut16 (
        .clk    (clk),
        .rst    (rst),
        .start  (start16),
        .op     (op16),
        .a      (a16),
        .b      (b16),
        .busy   (busy16),
        .done   (done16),
        .result (result16),
        .flag_z (z16),
        .flag_c (c16),
        .flag_v (v16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one operation, checks done latency, pulse width, result and flags.
    task automatic run_op(input bit wide, input logic [1:0] o, input logic [15:0] av,
                          input logic [15:0] bv, input logic [15:0] er, input logic ez,
                          input logic ec, input logic ev, input string tag);
        int n;
        int lat;
        lat = wide ? 16 : 8;
        @(negedge clk);
        if (wide) begin
            a16 = av; b16 = bv; op16 = o; start16 = 1'b1;
        end else begin
            a8 = av[7:0]; b8 = bv[7:0]; op8 = o; start8 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8 = 1'b0;
        start16 = 1'b0;
        check({tag, ".busy"}, 32'(wide ? busy16 : busy8), 32'd1);
        n = 0;
        while (!(wide ? done16 : done8) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".lat"}, 32'(n), 32'(lat));
        check({tag, ".res"}, wide ? 32'(result16) : 32'(result8), wide ? 32'(er) : 32'(er[7:0]));
        check({tag, ".z"}, 32'(wide ? z16 : z8), 32'(FlagsEn & ez));
        check({tag, ".c"}, 32'(wide ? c16 : c8), 32'(FlagsEn & ec));
        check({tag, ".v"}, 32'(wide ? v16 : v8), 32'(FlagsEn & ev));
        @(posedge clk);
        #1;
        check({tag, ".done_w"}, 32'(wide ? done16 : done8), 32'd0);
        check({tag, ".busy_end"}, 32'(wide ? busy16 : busy8), 32'd0);
    endtask

    initial begin
        int dones;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst.busy8", 32'(busy8), 32'd0);
        check("rst.done8", 32'(done8), 32'd0);
        check("rst.res8", 32'(result8), 32'd0);
        check("rst.flags8", 32'({z8, c8, v8}), 32'd0);
        check("rst.busy16", 32'(busy16), 32'd0);
        check("rst.res16", 32'(result16), 32'd0);
        check("rst.flags16", 32'({z16, c16, v16}), 32'd0);

        run_op(1'b0, 2'd2, 16'h3C, 16'h0F, 16'h4B, 1'b0, 1'b0, 1'b0, "add_3c_0f");
        run_op(1'b0, 2'd3, 16'h10, 16'h10, 16'h00, 1'b1, 1'b1, 1'b0, "sub_10_10");
        run_op(1'b0, 2'd3, 16'h00, 16'h01, 16'hFF, 1'b0, 1'b0, 1'b0, "sub_00_01");
        run_op(1'b0, 2'd2, 16'h7F, 16'h01, 16'h80, 1'b0, 1'b0, 1'b1, "add_7f_01");
        run_op(1'b0, 2'd2, 16'hFF, 16'h01, 16'h00, 1'b1, 1'b1, 1'b0, "add_ff_01");
        run_op(1'b0, 2'd0, 16'hF0, 16'h3C, 16'h30, 1'b0, 1'b0, 1'b0, "and_f0_3c");
        run_op(1'b0, 2'd1, 16'hF0, 16'h3C, 16'hFC, 1'b0, 1'b0, 1'b0, "or_f0_3c");

        // Extra starts and operand changes while busy must not disturb 0x12+0x34.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; op8 = 2'd2; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        dones = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a8 = 8'hFF; b8 = 8'hFF; op8 = 2'd0; start8 = 1'b1;
            end else begin
                start8 = (i == 8 || i == 9);
            end
            @(posedge clk);
            #1;
            if (done8) dones++;
        end
        check("busy_ign.dones", 32'(dones), 32'd1);
        check("busy_ign.res", 32'(result8), 32'h46);
        check("busy_ign.busy", 32'(busy8), 32'd0);

        // Reset during bit 4, with start raised alongside rst.
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h0F; op8 = 2'd2; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        start8 = 1'b0;
        check("rst_mid.busy", 32'(busy8), 32'd0);
        check("rst_mid.res", 32'(result8), 32'd0);
        check("rst_mid.flags", 32'({z8, c8, v8}), 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done8 || busy8) dones++;
        end
        check("rst_mid.quiet", 32'(dones), 32'd0);
        run_op(1'b0, 2'd2, 16'h3C, 16'h0F, 16'h4B, 1'b0, 1'b0, 1'b0, "after_rst");

        run_op(1'b1, 2'd3, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0, "w16_sub");
        run_op(1'b1, 2'd2, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, "w16_add_v");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
